// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard scoreboard. The bench and RTL both import it
// so they agree on default latencies and the result-class encoding.
package hazard_pkg;

    localparam int NREG_DEF     = 16;
    localparam int LOAD_LAT_DEF = 1;
    localparam int MUL_LAT_DEF  = 3;
    localparam int WB_DIST_DEF  = 2;

    // Result class of the decode-stage instruction. The reserved code behaves like ALU.
    typedef enum logic [1:0] {
        KIND_ALU  = 2'b00,
        KIND_LOAD = 2'b01,
        KIND_MUL  = 2'b10,
        KIND_RSVD = 2'b11
    } kind_e;

    // Cycles from issue until a result of this class can be bypassed.
    function automatic int resultLat(input logic [1:0] kind, input int loadLat, input int mulLat);
        case (kind)
            KIND_LOAD: return loadLat;
            KIND_MUL:  return mulLat;
            default:   return 0;
        endcase
    endfunction

endpackage

// File: rtl/hazard_sb_entry.sv
// One scoreboard slot: tracks whether a register has an in-flight writer, how long
// until that value is bypassable, and how long until it lands in the register file.
module hazard_sb_entry #(
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_i,
    input  logic          cancel_i,
    input  logic [CW-1:0] rdyLoad_i,
    input  logic [CW-1:0] wbLoad_i,
    output logic          busy_o,
    output logic [CW-1:0] rdyCnt_o
);

    logic          busy_q, busy_d;
    logic [CW-1:0] rdy_q, rdy_d;
    logic [CW-1:0] wb_q, wb_d;

    // A new writer always wins over a retirement or cancel in the same cycle;
    // otherwise a busy slot counts down and frees itself when writeback completes.
    always_comb begin
        busy_d = busy_q;
        rdy_d  = rdy_q;
        wb_d   = wb_q;
        if (load_i) begin
            busy_d = 1'b1;
            rdy_d  = rdyLoad_i;
            wb_d   = wbLoad_i;
        end else if (cancel_i) begin
            busy_d = 1'b0;
            rdy_d  = '0;
            wb_d   = '0;
        end else if (busy_q) begin
            rdy_d = (rdy_q != '0) ? rdy_q - CW'(1) : '0;
            wb_d  = (wb_q != '0) ? wb_q - CW'(1) : '0;
            if (wb_q <= CW'(1)) begin
                busy_d = 1'b0;
                rdy_d  = '0;
            end
        end
    end

    // Slot state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= 1'b0;
            rdy_q  <= '0;
            wb_q   <= '0;
        end else begin
            busy_q <= busy_d;
            rdy_q  <= rdy_d;
            wb_q   <= wb_d;
        end
    end

    assign busy_o   = busy_q;
    assign rdyCnt_o = rdy_q;

endmodule

// File: rtl/hazard_sb.sv
// Decode-stage hazard scoreboard: RAW/WAW/multiplier stalls, bypass selects and
// pipeline flush/stall control. Defining HAZARD_PERF_EN adds a StallCycles counter.
module hazard_sb import hazard_pkg::*; #(
    parameter int NREG     = NREG_DEF,
    parameter int LOAD_LAT = LOAD_LAT_DEF,
    parameter int MUL_LAT  = MUL_LAT_DEF,
    parameter int WB_DIST  = WB_DIST_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    IssueValidD,
    input  logic [$clog2(NREG)-1:0] RA1D,
    input  logic [$clog2(NREG)-1:0] RA2D,
    input  logic                    UseAD,
    input  logic                    UseBD,
    input  logic [$clog2(NREG)-1:0] WA3D,
    input  logic                    RegWriteD,
    input  logic [1:0]              KindD,
    input  logic                    CondExE,
    input  logic                    BranchMispredE,
    output logic                    StallF,
    output logic                    StallD,
    output logic                    FlushD,
    output logic                    FlushE,
    output logic                    ForwardAD,
`ifdef HAZARD_PERF_EN
    output logic [31:0]             StallCycles,
`endif
    output logic                    ForwardBD
);

    localparam int AW = $clog2(NREG);
    localparam int CW = $clog2(MUL_LAT + WB_DIST + 1);

    logic            issue;
    logic            rawA, rawB, waw, structural, stallD;
    logic [NREG-1:0] busyVec, loadVec, cancelVec;
    logic [CW-1:0]   rdyCnt [NREG];
    logic [CW-1:0]   issueRdy, issueWb;
    logic [CW-1:0]   mulCnt_q, mulCnt_d;
    logic [AW-1:0]   WA3E_q;
    logic            RegWriteE_q;

    // Hazard detection and pipeline control, purely from current state and decode inputs.
    always_comb begin
        rawA       = UseAD & busyVec[RA1D] & (rdyCnt[RA1D] != '0);
        rawB       = UseBD & busyVec[RA2D] & (rdyCnt[RA2D] != '0);
        waw        = RegWriteD & busyVec[WA3D];
        structural = (KindD == KIND_MUL) & (mulCnt_q != '0);
        stallD     = IssueValidD & (rawA | rawB | waw | structural);
        StallD     = stallD;
        FlushD     = BranchMispredE;
        FlushE     = stallD | BranchMispredE;
        StallF     = stallD & ~BranchMispredE;
        ForwardAD  = UseAD & busyVec[RA1D] & (rdyCnt[RA1D] == '0);
        ForwardBD  = UseBD & busyVec[RA2D] & (rdyCnt[RA2D] == '0);
        issue      = IssueValidD & ~stallD & ~BranchMispredE;
        issueRdy   = CW'(resultLat(KindD, LOAD_LAT, MUL_LAT));
        issueWb    = CW'(resultLat(KindD, LOAD_LAT, MUL_LAT) + WB_DIST);
    end

    // The multiplier is not pipelined: it stays occupied for MUL_LAT cycles after a mul issues.
    always_comb begin
        mulCnt_d = mulCnt_q;
        if (issue && (KindD == KIND_MUL)) begin
            mulCnt_d = CW'(MUL_LAT);
        end else if (mulCnt_q != '0) begin
            mulCnt_d = mulCnt_q - CW'(1);
        end
    end

    // Multiplier occupancy plus the destination of the instruction now in execute,
    // so a condition failure there can release its scoreboard slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mulCnt_q    <= '0;
            WA3E_q      <= '0;
            RegWriteE_q <= 1'b0;
        end else begin
            mulCnt_q    <= mulCnt_d;
            RegWriteE_q <= issue & RegWriteD;
            if (issue) begin
                WA3E_q <= WA3D;
            end
        end
    end

    for (genvar g = 0; g < NREG; g++) begin : gEntry
        assign loadVec[g]   = issue & RegWriteD & (WA3D == AW'(g));
        assign cancelVec[g] = RegWriteE_q & ~CondExE & (WA3E_q == AW'(g));

        hazard_sb_entry #(.CW(CW)) uEntry (
            .clk       (clk),
            .reset     (reset),
            .load_i    (loadVec[g]),
            .cancel_i  (cancelVec[g]),
            .rdyLoad_i (issueRdy),
            .wbLoad_i  (issueWb),
            .busy_o    (busyVec[g]),
            .rdyCnt_o  (rdyCnt[g])
        );
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stallCycles_q;

    // Free-running count of decode stall cycles; wraps naturally at 2^32.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stallCycles_q <= '0;
        end else if (stallD) begin
            stallCycles_q <= stallCycles_q + 32'd1;
        end
    end

    assign StallCycles = stallCycles_q;
`endif

endmodule

// File: tb/tb_hazard_sb.sv
// Directed bench for hazard_sb: each step drives decode/execute inputs, pushes the
// expected {StallF,StallD,FlushD,FlushE,ForwardAD,ForwardBD} and checks at the negedge.
module tb_hazard_sb;
    import hazard_pkg::*;

    typedef struct {
        string    tag;
        logic [5:0] exp;
    } sbItem_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       IssueValidD, UseAD, UseBD, RegWriteD, CondExE, BranchMispredE;
    logic [3:0] RA1D, RA2D, WA3D;
    logic [1:0] KindD;
    logic       StallF, StallD, FlushD, FlushE, ForwardAD, ForwardBD;
`ifdef HAZARD_PERF_EN
    logic [31:0] StallCycles;
`endif

    sbItem_t sbQ[$];
    int      total = 0;
    int      bad   = 0;

    hazard_sb dut (
        .clk            (clk),
        .reset          (reset),
        .IssueValidD    (IssueValidD),
        .RA1D           (RA1D),
        .RA2D           (RA2D),
        .UseAD          (UseAD),
        .UseBD          (UseBD),
        .WA3D           (WA3D),
        .RegWriteD      (RegWriteD),
        .KindD          (KindD),
        .CondExE        (CondExE),
        .BranchMispredE (BranchMispredE),
        .StallF         (StallF),
        .StallD         (StallD),
        .FlushD         (FlushD),
        .FlushE         (FlushE),
        .ForwardAD      (ForwardAD),
`ifdef HAZARD_PERF_EN
        .StallCycles    (StallCycles),
`endif
        .ForwardBD      (ForwardBD)
    );

    // Free-running clock, 10 time-unit period.
    always #5 clk = ~clk;

    // Drive one cycle of inputs and record what the control outputs must be.
    task automatic applyStimulus(input string tag, input logic valid,
                                 input logic [3:0] ra1, input logic useA,
                                 input logic [3:0] ra2, input logic useB,
                                 input logic [3:0] wa3, input logic regW,
                                 input logic [1:0] kind, input logic condEx,
                                 input logic mispred, input logic [5:0] exp);
        sbItem_t it;
        IssueValidD    = valid;
        RA1D           = ra1;
        UseAD          = useA;
        RA2D           = ra2;
        UseBD          = useB;
        WA3D           = wa3;
        RegWriteD      = regW;
        KindD          = kind;
        CondExE        = condEx;
        BranchMispredE = mispred;
        it.tag = tag;
        it.exp = exp;
        sbQ.push_back(it);
    endtask

    // Sample mid-cycle, compare against the oldest expectation, then advance past the edge.
    task automatic checkOutput();
        sbItem_t    it;
        logic [5:0] obs;
        @(negedge clk);
        obs = {StallF, StallD, FlushD, FlushE, ForwardAD, ForwardBD};
        total++;
        if (sbQ.size() == 0) begin
            bad++;
            $error("[TB] FAIL scoreboard_empty observed=%b expected=none", obs);
        end else begin
            it = sbQ.pop_front();
            assert (obs === it.exp) else begin
                bad++;
                $error("[TB] FAIL %s observed=%b expected=%b", it.tag, obs, it.exp);
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Directed sequence covering forwarding, load-use, multiplier, mispredict, cancel and reset.
    initial begin
        reset = 1'b1;
        applyStimulus("init", 0, 0, 0, 0, 0, 0, 0, KIND_ALU, 1, 0, 6'b000000);
        sbQ.delete();
        @(posedge clk);
        #1;

        applyStimulus("reset_idle", 0, 0, 0, 0, 0, 0, 0, KIND_ALU, 1, 0, 6'b000000);
        checkOutput();
        applyStimulus("reset_mispred", 1, 1, 1, 2, 1, 3, 1, KIND_MUL, 1, 1, 6'b001100);
        checkOutput();
        reset = 1'b0;

        applyStimulus("alu_issue_r1", 1, 0, 0, 0, 0, 1, 1, KIND_ALU, 1, 0, 6'b000000);
        checkOutput();
        applyStimulus("alu_fwd_r1", 1, 1, 1, 0, 0, 0, 0, KIND_ALU, 1, 0, 6'b000010);
        checkOutput();
        applyStimulus("alu_fwd_r1_late", 1, 1, 1, 0, 0, 0, 0, KIND_ALU, 1, 0, 6'b000010);
        checkOutput();
        applyStimulus("alu_retired_r1", 1, 1, 1, 0, 0, 0, 0, KIND_ALU, 1, 0, 6'b000000);
        checkOutput();

        applyStimulus("load_issue_r2", 1, 0, 0, 0, 0, 2, 1, KIND_LOAD, 1, 0, 6'b000000);
        checkOutput();
        applyStimulus("load_use_stall", 1, 0, 0, 2, 1, 0, 0, KIND_ALU, 1, 0, 6'b110100);
        checkOutput();
        applyStimulus("load_use_fwd", 1, 0, 0, 2, 1, 0, 0, KIND_ALU, 1, 0, 6'b000001);
        checkOutput();

        applyStimulus("mul_issue_r3", 1, 0, 0, 0, 0, 3, 1, KIND_MUL, 1, 0, 6'b000000);
        checkOutput();
        applyStimulus("mul_use_stall1", 1, 3, 1, 0, 0, 0, 0, KIND_ALU, 1, 0, 6'b110100);
        checkOutput();
        applyStimulus("mul_struct_stall", 1, 0, 0, 0, 0, 6, 1, KIND_MUL, 1, 0, 6'b110100);
        checkOutput();
        applyStimulus("mul_use_stall3", 1, 3, 1, 0, 0, 0, 0, KIND_ALU, 1, 0, 6'b110100);
        checkOutput();
        applyStimulus("mul_use_fwd", 1, 3, 1, 0, 0, 0, 0, KIND_ALU, 1, 0, 6'b000010);
        checkOutput();
        applyStimulus("mul_second_ok", 1, 0, 0, 0, 0, 6, 1, KIND_MUL, 1, 0, 6'b000000);
        checkOutput();

        applyStimulus("load_issue_r7", 1, 0, 0, 0, 0, 7, 1, KIND_LOAD, 1, 0, 6'b000000);
        checkOutput();
        applyStimulus("mispred_in_stall", 1, 7, 1, 0, 0, 0, 0, KIND_ALU, 1, 1, 6'b011100);
        checkOutput();
        applyStimulus("mispred_no_issue", 1, 0, 0, 0, 0, 9, 1, KIND_ALU, 1, 1, 6'b001100);
        checkOutput();
        applyStimulus("mispred_after", 1, 9, 1, 7, 1, 0, 0, KIND_ALU, 1, 0, 6'b000001);
        checkOutput();

        applyStimulus("alu_issue_r4", 1, 0, 0, 0, 0, 4, 1, KIND_ALU, 1, 0, 6'b000000);
        checkOutput();
        applyStimulus("condfail_r4", 0, 0, 0, 0, 0, 0, 0, KIND_ALU, 0, 0, 6'b000000);
        checkOutput();
        applyStimulus("read_cancel_r4", 1, 4, 1, 0, 0, 0, 0, KIND_ALU, 1, 0, 6'b000000);
        checkOutput();

        applyStimulus("waw_first_r10", 1, 0, 0, 0, 0, 10, 1, KIND_ALU, 1, 0, 6'b000000);
        checkOutput();
        applyStimulus("waw_stall_r10", 1, 0, 0, 0, 0, 10, 1, KIND_ALU, 1, 0, 6'b110100);
        checkOutput();

        applyStimulus("mul_issue_r5", 1, 0, 0, 0, 0, 5, 1, KIND_MUL, 1, 0, 6'b000000);
        checkOutput();
        applyStimulus("invalid_no_stall", 0, 5, 1, 0, 0, 0, 0, KIND_ALU, 1, 0, 6'b000000);
        checkOutput();
        applyStimulus("mul_r5_stall", 1, 5, 1, 0, 0, 0, 0, KIND_ALU, 1, 0, 6'b110100);
        checkOutput();

        reset = 1'b1;
        applyStimulus("in_reset_r5", 1, 5, 1, 0, 0, 0, 0, KIND_ALU, 1, 0, 6'b000000);
        checkOutput();
        reset = 1'b0;
        applyStimulus("post_reset_r5", 1, 5, 1, 0, 0, 0, 0, KIND_ALU, 1, 0, 6'b000000);
        checkOutput();

`ifdef HAZARD_PERF_EN
        total++;
        assert (StallCycles === 32'd0) else begin
            bad++;
            $error("[TB] FAIL stall_cycles observed=%0d expected=0", StallCycles);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
